// File: rtl/filter_seq_pkg.sv
// Shared types and default sizing for the ADC pulse-shaping filter sequencer.
package filter_seq_pkg;

  localparam int unsigned DW          = 27;
  localparam int unsigned TS_W        = 32;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned FLUSH_N_DEF = 2;
  localparam int unsigned WARMUP_DEF  = 16;
  localparam int unsigned HOLDOFF_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    WARMUP,
    ARMED,
    PEAK,
    HOLDOFF
  } state_t;

  typedef struct packed {
    logic signed [DW-1:0] peak;
    logic [TS_W-1:0]      ts;
  } event_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/filter_seq_ctrl_peak_tracker.sv
// Running maximum of the filter output and the timestamp of its first occurrence.
module filter_seq_ctrl_peak_tracker
  import filter_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic signed [DW-1:0] sample,
  input  logic [TS_W-1:0]      ts,
  output event_t               peak
);

  localparam logic signed [DW-1:0] PEAK_MIN = {1'b1, {(DW-1){1'b0}}};

  event_t peak_q;
  event_t peak_d;

  // Clear restarts from the most negative value so the enabled sample always wins.
  always_comb begin
    peak_d = peak_q;
    if (clear) begin
      peak_d.peak = PEAK_MIN;
      peak_d.ts   = '0;
    end
    if (en && (sample > peak_d.peak)) begin
      peak_d.peak = sample;
      peak_d.ts   = ts;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;

endmodule

// File: rtl/filter_seq_ctrl.sv
// Filter sequencer: flush, warm-up, threshold trigger, peak capture, one-deep event output.
// Optional pile-up rejection during holdoff is enabled by defining PILEUP_REJECT_EN.
module filter_seq_ctrl
  import filter_seq_pkg::*;
#(
  parameter int unsigned FLUSH_N   = FLUSH_N_DEF,
  parameter int unsigned WARMUP_N  = WARMUP_DEF,
  parameter int unsigned HOLDOFF_N = HOLDOFF_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic signed [DW-1:0] threshold,
  input  logic signed [DW-1:0] filt_data,
  output logic                 filt_run,
  output logic                 busy,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic signed [DW-1:0] ev_peak,
  output logic [TS_W-1:0]      ev_time,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          pileup_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  event_t           ev_q, ev_d;
  logic             ev_valid_q, ev_valid_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [15:0]      pileup_cnt_q, pileup_cnt_d;
  logic             filt_run_q, filt_run_d;
  logic             busy_q, busy_d;

  logic   above_c;
  logic   trk_clear_c;
  logic   trk_en_c;
  logic   fin_c;
  logic   pileup_c;
  logic   slot_free_c;
  event_t trk_c;

  assign above_c = filt_data > threshold;

  filter_seq_ctrl_peak_tracker u_peak (
    .clk    (clk),
    .reset  (reset),
    .clear  (trk_clear_c),
    .en     (trk_en_c),
    .sample (filt_data),
    .ts     (ts_q),
    .peak   (trk_c)
  );

  // Sequencing; stop overrides every state, including IDLE+start.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ts_d        = '0;
    trk_clear_c = 1'b0;
    trk_en_c    = 1'b0;
    fin_c       = 1'b0;
    pileup_c    = 1'b0;

    if (state_q inside {ARMED, PEAK, HOLDOFF}) begin
      ts_d = ts_q + TS_W'(1);
    end

    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end
        end
        FLUSH: begin
          if (cnt_q == CNT_W'(FLUSH_N - 1)) begin
            state_d = WARMUP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WARMUP: begin
          if (cnt_q == CNT_W'(WARMUP_N - 1)) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ARMED: begin
          if (above_c) begin
            state_d     = PEAK;
            trk_clear_c = 1'b1;
            trk_en_c    = 1'b1;
          end
        end
        PEAK: begin
          if (above_c) begin
            trk_en_c = 1'b1;
          end else begin
            state_d = HOLDOFF;
            cnt_d   = '0;
`ifndef PILEUP_REJECT_EN
            fin_c   = 1'b1;
`endif
          end
        end
        HOLDOFF: begin
`ifdef PILEUP_REJECT_EN
          // Pending event stays in the tracker; a new crossing replaces it.
          if (above_c) begin
            pileup_c    = 1'b1;
            state_d     = PEAK;
            cnt_d       = '0;
            trk_clear_c = 1'b1;
            trk_en_c    = 1'b1;
          end else if (cnt_q == CNT_W'(HOLDOFF_N - 1)) begin
            state_d = ARMED;
            cnt_d   = '0;
            fin_c   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          if (cnt_q == CNT_W'(HOLDOFF_N - 1)) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // One-deep output slot; a same-cycle handshake makes room for the new event.
  always_comb begin
    ev_d         = ev_q;
    ev_valid_d   = ev_valid_q;
    drop_cnt_d   = drop_cnt_q;
    pileup_cnt_d = pileup_cnt_q;
    slot_free_c  = !ev_valid_q || ev_ready;

    if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
    if (fin_c) begin
      if (slot_free_c) begin
        ev_d       = trk_c;
        ev_valid_d = 1'b1;
      end else begin
        drop_cnt_d = sat_inc16(drop_cnt_q);
      end
    end
    if (pileup_c) begin
      pileup_cnt_d = sat_inc16(pileup_cnt_q);
    end

    filt_run_d = state_d inside {WARMUP, ARMED, PEAK, HOLDOFF};
    busy_d     = state_d != IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ts_q         <= '0;
      ev_q         <= '0;
      ev_valid_q   <= 1'b0;
      drop_cnt_q   <= '0;
      pileup_cnt_q <= '0;
      filt_run_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ts_q         <= ts_d;
      ev_q         <= ev_d;
      ev_valid_q   <= ev_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      pileup_cnt_q <= pileup_cnt_d;
      filt_run_q   <= filt_run_d;
      busy_q       <= busy_d;
    end
  end

  assign filt_run   = filt_run_q;
  assign busy       = busy_q;
  assign ev_valid   = ev_valid_q;
  assign ev_peak    = ev_q.peak;
  assign ev_time    = ev_q.ts;
  assign drop_cnt   = drop_cnt_q;
  assign pileup_cnt = pileup_cnt_q;

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Bench for filter_seq_ctrl: directed vector table, hand sequences and random traffic against a behavioural model.
module tb_filter_seq_ctrl;
  import filter_seq_pkg::*;

  localparam int FLUSH_N   = 2;
  localparam int WARMUP_N  = 16;
  localparam int HOLDOFF_N = 8;

  localparam int M_IDLE  = 0;
  localparam int M_FLUSH = 1;
  localparam int M_WARM  = 2;
  localparam int M_ARMED = 3;
  localparam int M_PEAK  = 4;
  localparam int M_HOLD  = 5;

  logic clk = 1'b0;
  logic reset, start, stop, ev_ready;
  logic signed [DW-1:0] threshold, filt_data;
  logic filt_run, busy, ev_valid;
  logic signed [DW-1:0] ev_peak;
  logic [TS_W-1:0] ev_time;
  logic [15:0] drop_cnt, pileup_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  filter_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .threshold  (threshold),
    .filt_data  (filt_data),
    .filt_run   (filt_run),
    .busy       (busy),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_peak    (ev_peak),
    .ev_time    (ev_time),
    .drop_cnt   (drop_cnt),
    .pileup_cnt (pileup_cnt)
  );

  // Behavioural model state: mode with down-counting dwell, pulse max, one output slot.
  int                   m_mode;
  int                   m_left;
  logic [TS_W-1:0]      m_ts;
  logic signed [DW-1:0] m_pk;
  logic [TS_W-1:0]      m_pt;
  logic                 m_valid;
  logic signed [DW-1:0] m_opk;
  logic [TS_W-1:0]      m_ot;
  int                   m_drop;
  int                   m_pile;

  task automatic model_step(input logic rst, input logic st, input logic sp, input logic rdy,
                            input logic signed [DW-1:0] thr, input logic signed [DW-1:0] fd);
    logic            fin;
    logic [TS_W-1:0] ts_now;
    if (rst) begin
      m_mode = M_IDLE; m_left = 0; m_ts = '0; m_pk = '0; m_pt = '0;
      m_valid = 1'b0; m_opk = '0; m_ot = '0; m_drop = 0; m_pile = 0;
      return;
    end
    fin    = 1'b0;
    ts_now = m_ts;
    m_ts   = (m_mode >= M_ARMED) ? ts_now + 1 : '0;
    if (m_valid && rdy) m_valid = 1'b0;
    if (sp) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (st) begin m_mode = M_FLUSH; m_left = FLUSH_N; end
        M_FLUSH: begin
          m_left--;
          if (m_left == 0) begin m_mode = M_WARM; m_left = WARMUP_N; end
        end
        M_WARM: begin
          m_left--;
          if (m_left == 0) m_mode = M_ARMED;
        end
        M_ARMED: if (fd > thr) begin m_mode = M_PEAK; m_pk = fd; m_pt = ts_now; end
        M_PEAK: begin
          if (fd > thr) begin
            if (fd > m_pk) begin m_pk = fd; m_pt = ts_now; end
          end else begin
            m_mode = M_HOLD; m_left = HOLDOFF_N;
`ifndef PILEUP_REJECT_EN
            fin = 1'b1;
`endif
          end
        end
        M_HOLD: begin
`ifdef PILEUP_REJECT_EN
          if (fd > thr) begin
            if (m_pile < 65535) m_pile++;
            m_mode = M_PEAK; m_pk = fd; m_pt = ts_now;
          end else
`endif
          begin
            m_left--;
            if (m_left == 0) begin
              m_mode = M_ARMED;
`ifdef PILEUP_REJECT_EN
              fin = 1'b1;
`endif
            end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
    if (fin) begin
      if (!m_valid) begin m_valid = 1'b1; m_opk = m_pk; m_ot = m_pt; end
      else if (m_drop < 65535) m_drop++;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  task automatic compare_all();
    check("filt_run", 64'(filt_run), 64'(m_mode >= M_WARM));
    check("busy", 64'(busy), 64'(m_mode != M_IDLE));
    check("ev_valid", 64'(ev_valid), 64'(m_valid));
    check("ev_peak", 64'(ev_peak), 64'(m_opk));
    check("ev_time", 64'(ev_time), 64'(m_ot));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("pileup_cnt", 64'(pileup_cnt), 64'(m_pile));
  endtask

  logic signed [DW-1:0] cur_thr;

  task automatic step(input logic st, input logic sp, input logic rdy, input logic signed [DW-1:0] fd);
    start = st; stop = sp; ev_ready = rdy; threshold = cur_thr; filt_data = fd;
    @(posedge clk);
    model_step(reset, st, sp, rdy, cur_thr, fd);
    #1;
    compare_all();
  endtask

  task automatic idle_steps(input int n, input logic signed [DW-1:0] fd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, fd);
  endtask

  typedef struct {
    logic                 st;
    logic signed [DW-1:0] fd;
    logic                 exp_run;
    logic                 exp_valid;
    logic signed [DW-1:0] exp_peak;
    logic [TS_W-1:0]      exp_time;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic st, input int fd, input logic run, input logic vld,
                         input int pk, input int tm);
    vec_t v;
    v.st = st; v.fd = DW'(fd); v.exp_run = run; v.exp_valid = vld;
    v.exp_peak = DW'(pk); v.exp_time = TS_W'(tm);
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulse[7];
    logic last_valid;
    int   last_peak;

    // Start, flush (filt_run low 2 cycles), warm-up with an above-threshold input that must be ignored.
    add_vec(1'b1, 0, 1'b0, 1'b0, 0, 0);
    add_vec(1'b0, 0, 1'b0, 1'b0, 0, 0);
    add_vec(1'b0, 0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < WARMUP_N; i++) add_vec(1'b0, 500, 1'b1, 1'b0, 0, 0);
    pulse = '{0, 50, 150, 300, 300, 120, 90};
    for (int i = 0; i < 6; i++) add_vec(1'b0, pulse[i], 1'b1, 1'b0, 0, 0);
`ifdef PILEUP_REJECT_EN
    last_valid = 1'b0; last_peak = 0;
`else
    last_valid = 1'b1; last_peak = 300;
`endif
    add_vec(1'b0, pulse[6], 1'b1, last_valid, last_peak, last_valid ? 3 : 0);

    cur_thr = DW'(100);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("rst_filt_run", 64'(filt_run), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ev_valid", 64'(ev_valid), 64'(0));
    check("rst_ev_peak", 64'(ev_peak), 64'(0));
    check("rst_ev_time", 64'(ev_time), 64'(0));
    check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    check("rst_pileup_cnt", 64'(pileup_cnt), 64'(0));
    reset = 1'b0;

    // T1/T2 vector table
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].st, 1'b0, 1'b0, tbl[i].fd);
      check($sformatf("vec%0d_filt_run", i), 64'(filt_run), 64'(tbl[i].exp_run));
      check($sformatf("vec%0d_ev_valid", i), 64'(ev_valid), 64'(tbl[i].exp_valid));
      check($sformatf("vec%0d_ev_peak", i), 64'(ev_peak), 64'(tbl[i].exp_peak));
      check($sformatf("vec%0d_ev_time", i), 64'(ev_time), 64'(tbl[i].exp_time));
    end
    idle_steps(HOLDOFF_N - 1, '0);
`ifdef PILEUP_REJECT_EN
    check("t2_valid_before_holdoff_end", 64'(ev_valid), 64'(0));
`else
    check("t2_valid_held", 64'(ev_valid), 64'(1));
`endif
    idle_steps(1, '0);
    check("t2_valid", 64'(ev_valid), 64'(1));
    check("t2_peak", 64'(ev_peak), 64'(300));
    check("t2_time", 64'(ev_time), 64'(3));
    step(1'b0, 1'b0, 1'b1, '0);
    check("t2_consumed", 64'(ev_valid), 64'(0));

    // T3: two pulses with no consumer
    step(1'b0, 1'b0, 1'b0, DW'(200));
    step(1'b0, 1'b0, 1'b0, DW'(220));
    idle_steps(13, '0);
    check("t3_first_valid", 64'(ev_valid), 64'(1));
    check("t3_first_peak", 64'(ev_peak), 64'(220));
    step(1'b0, 1'b0, 1'b0, DW'(400));
    idle_steps(13, '0);
    check("t3_held_peak", 64'(ev_peak), 64'(220));
    check("t3_drop_cnt", 64'(drop_cnt), 64'(1));
    step(1'b0, 1'b0, 1'b1, '0);

    // T4: stop in the middle of a pulse with an event already queued
    step(1'b0, 1'b0, 1'b0, DW'(250));
    idle_steps(13, '0);
    step(1'b0, 1'b0, 1'b0, DW'(600));
    step(1'b0, 1'b0, 1'b0, DW'(700));
    step(1'b0, 1'b1, 1'b0, DW'(700));
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_filt_run", 64'(filt_run), 64'(0));
    check("t4_kept_valid", 64'(ev_valid), 64'(1));
    check("t4_kept_peak", 64'(ev_peak), 64'(250));
    idle_steps(12, '0);
    check("t4_no_new_drop", 64'(drop_cnt), 64'(1));
    check("t4_still_peak", 64'(ev_peak), 64'(250));
    step(1'b0, 1'b0, 1'b1, '0);

    // T6: start+stop together in IDLE, then a negative threshold
    step(1'b1, 1'b1, 1'b0, '0);
    check("t6_stay_idle", 64'(busy), 64'(0));
    cur_thr = -DW'(50);
    step(1'b1, 1'b0, 1'b0, -DW'(100));
    idle_steps(FLUSH_N + WARMUP_N, -DW'(100));
    check("t6_no_event", 64'(ev_valid), 64'(0));
    step(1'b0, 1'b0, 1'b0, -DW'(10));
    step(1'b0, 1'b0, 1'b0, -DW'(10));
    idle_steps(11, -DW'(60));
    check("t6_valid", 64'(ev_valid), 64'(1));
    check("t6_peak", 64'(ev_peak), 64'(-10));
    step(1'b0, 1'b0, 1'b1, -DW'(60));
    cur_thr = DW'(100);

`ifdef PILEUP_REJECT_EN
    // T5: re-crossing on the third holdoff cycle
    step(1'b0, 1'b0, 1'b0, DW'(200));
    idle_steps(3, '0);
    step(1'b0, 1'b0, 1'b0, DW'(350));
    check("t5_pileup_cnt", 64'(pileup_cnt), 64'(1));
    idle_steps(13, '0);
    check("t5_valid", 64'(ev_valid), 64'(1));
    check("t5_peak", 64'(ev_peak), 64'(350));
    check("t5_drop_cnt", 64'(drop_cnt), 64'(1));
    step(1'b0, 1'b0, 1'b1, '0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int v;
      logic st, sp, rdy;
      logic signed [DW-1:0] fd;
      if ($urandom_range(199, 0) == 0) begin
        case ($urandom_range(3, 0))
          0: cur_thr = DW'(100);
          1: cur_thr = -DW'(50);
          2: cur_thr = '0;
          default: cur_thr = DW'(int'($urandom_range(300, 0)) - 100);
        endcase
      end
      v  = int'($urandom_range(600, 0)) - 200;
      fd = DW'(v);
      if ($urandom_range(99, 0) == 0) fd = {1'b0, {(DW-1){1'b1}}};
      if ($urandom_range(99, 0) == 0) fd = {1'b1, {(DW-1){1'b0}}};
      st  = ($urandom_range(19, 0) == 0);
      sp  = ($urandom_range(299, 0) == 0);
      rdy = ($urandom_range(3, 0) == 0);
      reset = ($urandom_range(999, 0) == 0);
      step(st, sp, rdy, fd);
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
